// File: rtl/glb_arb_pkg.sv
// -----------------------------------------------------------------------------
// glb_arb_pkg
// Shared types and helpers for the GLB stream arbiter.
//   arb_state_e        : block-level arbiter state.
//   ARB_LEN_WIDTH      : default width of the header length field.
//   ARB_MAX_DATA_WIDTH : widest stream word the length helper accepts.
//   hdr_len()          : extracts the block length N from a header word.
// -----------------------------------------------------------------------------
package glb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_HEADER  = 2'd1,
    ARB_PAYLOAD = 2'd2
  } arb_state_e;

  localparam int ARB_LEN_WIDTH      = 16;
  localparam int ARB_MAX_DATA_WIDTH = 64;

  // Returns the low len_w bits of a header word (zero-extended). The bits
  // above the length field are user data and are never interpreted.
  function automatic logic [ARB_MAX_DATA_WIDTH-1:0] hdr_len(
    input logic [ARB_MAX_DATA_WIDTH-1:0] word,
    input int unsigned                   len_w
  );
    logic [ARB_MAX_DATA_WIDTH-1:0] mask;
    mask = (len_w >= ARB_MAX_DATA_WIDTH) ? '1
         : ((ARB_MAX_DATA_WIDTH'(1) << len_w) - ARB_MAX_DATA_WIDTH'(1));
    return word & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotating-priority search. Scans req starting at ptr and
// wrapping modulo NUM_PORTS; the first asserted request wins.
//   req     : request vector, one bit per port.
//   ptr     : port with highest priority this cycle.
//   gnt_idx : index of the winning port (0 when none).
//   gnt_any : at least one request is asserted.
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_WIDTH = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [IDX_WIDTH-1:0] gnt_idx,
  output logic                 gnt_any
);

  always_comb begin
    int k;
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    gnt_any = 1'b0;
    gnt_idx = '0;
    k       = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      k = (int'(ptr) + i) % NUM_PORTS;
      if (!gnt_any && req[k]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/glb_stream_arbiter.sv
// -----------------------------------------------------------------------------
// glb_stream_arbiter
// Shares one GLB-bound ready/valid stream between NUM_PORTS producers. Each
// producer sends a header word (low LEN_WIDTH bits = N) followed by N payload
// words; a whole block is granted at a time, round-robin between blocks.
//   clk, rst_n   : clock, asynchronous active-low reset.
//   flush        : synchronous abort back to IDLE, active high.
//   in_data      : producer words, port i at [i*DATA_WIDTH +: DATA_WIDTH].
//   in_valid     : producer valid.       in_ready  : producer ready.
//   out_data     : granted word to GLB.  out_valid : granted valid.
//   out_ready    : GLB backpressure.
//   grant_idx    : granted port.         grant_valid : a block is in progress.
//   block_done   : registered pulse the cycle after a block's last word.
// -----------------------------------------------------------------------------
module glb_stream_arbiter
  import glb_arb_pkg::*;
#(
  parameter  int NUM_PORTS  = 2,
  parameter  int DATA_WIDTH = 17,
  parameter  int LEN_WIDTH  = ARB_LEN_WIDTH,
  localparam int IDX_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IDX_WIDTH-1:0]            grant_idx,
  output logic                            grant_valid,
  output logic                            block_done
);

  arb_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic                 block_done_q, block_done_d;

  logic [IDX_WIDTH-1:0]  arb_idx;
  logic                  arb_any;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  active;
  logic                  granted;
  logic                  xfer;
  logic [LEN_WIDTH-1:0]  hdr_n;
  logic [IDX_WIDTH-1:0]  next_ptr;

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_rr (
    .req    (in_valid),
    .ptr    (rr_ptr_q),
    .gnt_idx(arb_idx),
    .gnt_any(arb_any)
  );

  // Mux of the granted producer's word and valid.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx_q == IDX_WIDTH'(i)) begin
        sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = in_valid[i];
      end
    end
  end

  // flush gates the handshake so no word can move in the cycle it aborts.
  assign active  = (state_q != ARB_IDLE);
  assign granted = active && !flush;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_ready[i] = granted && (grant_idx_q == IDX_WIDTH'(i)) && out_ready;
    end
  end

  assign out_valid   = granted && sel_valid;
  assign out_data    = active ? sel_data : '0;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = active;
  assign block_done  = block_done_q;

  assign xfer     = out_valid && out_ready;
  assign hdr_n    = LEN_WIDTH'(hdr_len(ARB_MAX_DATA_WIDTH'(out_data), LEN_WIDTH));
  assign next_ptr = (grant_idx_q == IDX_WIDTH'(NUM_PORTS - 1)) ? '0
                  : grant_idx_q + IDX_WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_idx_d  = grant_idx_q;
    remaining_d  = remaining_q;
    block_done_d = 1'b0;

    if (flush) begin
      state_d     = ARB_IDLE;
      remaining_d = '0;
      rr_ptr_d    = '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          // Grant is registered here; the header moves no earlier than next cycle.
          if (arb_any) begin
            grant_idx_d = arb_idx;
            state_d     = ARB_HEADER;
          end
        end
        ARB_HEADER: begin
          if (xfer) begin
            remaining_d = hdr_n;
            if (hdr_n == '0) begin
              state_d      = ARB_IDLE;
              rr_ptr_d     = next_ptr;
              block_done_d = 1'b1;
            end else begin
              state_d = ARB_PAYLOAD;
            end
          end
        end
        ARB_PAYLOAD: begin
          if (xfer) begin
            remaining_d = remaining_q - LEN_WIDTH'(1);
            if (remaining_q == LEN_WIDTH'(1)) begin
              state_d      = ARB_IDLE;
              rr_ptr_d     = next_ptr;
              block_done_d = 1'b1;
            end
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // NOTE: registers update with non-blocking assignments so every flop
  // samples its _d value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      grant_idx_q  <= '0;
      remaining_q  <= '0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_idx_q  <= grant_idx_d;
      remaining_q  <= remaining_d;
      block_done_q <= block_done_d;
    end
  end

endmodule

// File: doc/glb_stream_arbiter.md
Name: glb_stream_arbiter

Overview:
- Shares one GLB-bound ready/valid stream port between NUM_PORTS producers.
- Each producer sends length-prefixed blocks: one header word whose low 16 bits give N, then exactly N payload words.
- The arbiter grants a whole block at a time, with round-robin fairness, and passes the granted producer's data straight through.
- Sits between tile-side stream sources and the GLB write sink; block boundaries are never interleaved.

Parameters:
- NUM_PORTS, 2, number of requesting producers (1..8).
- DATA_WIDTH, 17, stream word width.
- LEN_WIDTH, 16, header length field width, taken from data[LEN_WIDTH-1:0].
- IDX_WIDTH, max(1,$clog2(NUM_PORTS)), grant index width (derived, not overridden).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort/clear, active high.
- in_data  input  NUM_PORTS*DATA_WIDTH  producer words; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_PORTS  producer valid.
- in_ready  output  NUM_PORTS  producer ready.
- out_data  output  DATA_WIDTH  muxed word to GLB.
- out_valid  output  1  muxed valid.
- out_ready  input  1  GLB ready (backpressure).
- grant_idx  output  IDX_WIDTH  currently granted port.
- grant_valid  output  1  high in HEADER and PAYLOAD.
- block_done  output  1  one-cycle pulse, registered, the cycle after the last word of a block transfers.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, rr_ptr=0, grant_idx=0, remaining=0, block_done=0.
  - Outputs: in_ready=0, out_valid=0, out_data=0.
- Transfer rule: a word moves when out_valid && out_ready in HEADER/PAYLOAD.
- Combinational pass-through while granted:
  - out_valid = in_valid[grant_idx]; out_data = in_data slice of grant_idx.
  - in_ready[grant_idx] = out_ready; every other in_ready = 0.
- In IDLE: all in_ready=0, out_valid=0, out_data=0.
- IDLE:
  - If any in_valid, register grant_idx = first asserted port searching rr_ptr, rr_ptr+1, ... (mod NUM_PORTS), then go to HEADER.
  - Arbitration costs exactly one cycle; the header cannot transfer in the IDLE cycle.
- HEADER: on transfer, remaining <= data[LEN_WIDTH-1:0].
  - If N==0: block complete, go to IDLE.
  - Else go to PAYLOAD.
- PAYLOAD: each transfer decrements remaining. A transfer with remaining==1 completes the block; go to IDLE.
- On block completion:
  - rr_ptr <= (grant_idx+1) mod NUM_PORTS.
  - block_done pulses high the next cycle.
- Backpressure: out_ready=0 or in_valid=0 simply stalls; the count changes only on a transfer.
- Grant stickiness: the granted producer deasserting valid mid-block does not release the grant, and other producers are ignored until completion.
- Bit 16 of data is carried unmodified; it is never interpreted.
- Maximum block is N=65535 (header + 65535 words); the counter never wraps because it only decrements from N to 0.
- flush=1 (takes priority over any same-cycle transfer):
  - Next state IDLE, remaining=0, rr_ptr=0, no block_done.
  - While flush=1, all in_ready=0 and out_valid=0, so no transfer occurs.
- Async reset mid-block aborts identically to flush and returns to reset values.
- NUM_PORTS=1 degenerates to a length-tracking pass-through with the one-cycle IDLE bubble.

Decomposition:
- Package glb_arb_pkg:
  - state enum {ARB_IDLE, ARB_HEADER, ARB_PAYLOAD}.
  - LEN_WIDTH default constant.
  - Helper function extracting header length from a data word.
- Sub-module rr_arbiter (combinational): inputs req[NUM_PORTS] and ptr; outputs gnt_idx and gnt_any. It performs the rotating priority search.

Test Plan:
- Single block: port0 sends header 3, payload A,B,C, out_ready=1 → IDLE cycle, then 4 consecutive transfers in order; block_done pulses once on the cycle after C; rr_ptr=1.
- Contention: both ports valid from reset, each sends header 2 + 2 words → port0 block completes fully, then port1; no interleaving; grant_idx 0 then 1; two block_done pulses.
- Zero-length block: port1 header 0 → exactly one transfer, then IDLE; block_done pulses; next grant search starts at port0.
- Backpressure: header 4, out_ready toggling randomly and port0 valid dropping mid-block → exactly 5 transfers, data order preserved; port1 in_ready stays 0 throughout.
- Flush mid-block: after header 10 and 3 payload words, flush for 1 cycle → no block_done; state IDLE; subsequent header 2 block from port1 transfers correctly.
- Async reset mid-payload: drop rst_n between clock edges → in_ready/out_valid go 0 immediately; after release, arbitration restarts at port0.
